// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, FSM state type and alignment helper
// for the memory-access pipeline stage.
package mem_stage_pkg;
    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;
    typedef enum logic {IDLE, BUSY} mem_state_t;
    function automatic logic is_misaligned(input logic [1:0] addr);
        return addr != 2'b00;
    endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs and MEM/WB outputs of the memory stage;
// master is the upstream/downstream pipeline, slave is the stage itself.
interface mem_stage_if;
    import mem_stage_pkg::*;
    logic                  MemWrite_in, MemRead_in, MemToReg_in, RegWrite_in;
    logic [WORD_W-1:0]     AluResult_in, WriteData_in;
    logic [REG_ADDR_W-1:0] Rd_in;
    logic                  Stall_out;
    logic                  MemToReg_out, RegWrite_out, MisalignFault_out;
    logic [WORD_W-1:0]     ReadData_out, AluResult_out;
    logic [REG_ADDR_W-1:0] Rd_out;
    modport master (
        output MemWrite_in, MemRead_in, MemToReg_in, RegWrite_in,
               AluResult_in, WriteData_in, Rd_in,
        input  Stall_out, MemToReg_out, RegWrite_out, MisalignFault_out,
               ReadData_out, AluResult_out, Rd_out
    );
    modport slave (
        input  MemWrite_in, MemRead_in, MemToReg_in, RegWrite_in,
               AluResult_in, WriteData_in, Rd_in,
        output Stall_out, MemToReg_out, RegWrite_out, MisalignFault_out,
               ReadData_out, AluResult_out, Rd_out
    );
endinterface

// File: rtl/mem_stage_data_mem.sv
// data_mem: single-port synchronous RAM, read-first, registered read data.
// Contents are intentionally not reset.
module data_mem import mem_stage_pkg::*; #(
    parameter  int DEPTH_WORDS = 256,
    localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with a fixed-latency data memory, upstream
// stall, misalignment fault and one-cycle pass-through for non-memory ops.
module mem_stage import mem_stage_pkg::*; #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    mem_state_t        state_q;
    logic [3:0]        cnt_q;
    logic [WORD_W-1:0] rdata;
    logic              mem_op, misal, done, fire, we;
    always_comb begin
        mem_op        = bus.MemRead_in | bus.MemWrite_in;
        misal         = state_q == IDLE && mem_op && is_misaligned(bus.AluResult_in[1:0]);
        done          = state_q == BUSY && cnt_q == 4'd0;
        fire          = done || (state_q == IDLE && !mem_op);
        we            = done && bus.MemWrite_in;
        bus.Stall_out = state_q == IDLE ? mem_op && !misal : cnt_q != 4'd0;
    end
    // RAM reads every cycle from the held address, so rdata is fresh by the final edge
    data_mem #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
        .clk   (clk),
        .we    (we),
        .addr  (bus.AluResult_in[ADDR_W+1:2]),
        .wdata (bus.WriteData_in),
        .rdata (rdata)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q               <= IDLE;
            cnt_q                 <= 4'd0;
            bus.RegWrite_out      <= 1'b0;
            bus.MemToReg_out      <= 1'b0;
            bus.ReadData_out      <= '0;
            bus.AluResult_out     <= '0;
            bus.Rd_out            <= '0;
            bus.MisalignFault_out <= 1'b0;
        end else begin
            bus.RegWrite_out      <= fire && bus.RegWrite_in;
            bus.MemToReg_out      <= fire && bus.MemToReg_in;
            bus.ReadData_out      <= done && bus.MemRead_in && !bus.MemWrite_in ? rdata : '0;
            bus.AluResult_out     <= bus.AluResult_in;
            bus.Rd_out            <= bus.Rd_in;
            bus.MisalignFault_out <= misal;
            if (state_q == IDLE && mem_op && !misal) begin
                state_q <= BUSY;
                cnt_q   <= 4'(LATENCY - 1);
            end else if (state_q == BUSY) begin
                state_q <= done ? IDLE : BUSY;
                cnt_q   <= done ? cnt_q : cnt_q - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random operations checked against a
// transaction-level model of the memory stage (word array + latency rule).
module tb_mem_stage;
    localparam int LAT = 2;
    localparam int DW  = 256;
    logic clk, rst_n;
    int total, bad;
    logic [31:0] ref_mem [DW];
    bit          known   [DW];
    mem_stage_if bus ();
    mem_stage #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, o, e);
        end
    endtask
    task automatic drive(input bit w, r, m, rw, input logic [31:0] a, d, input logic [4:0] rd);
        bus.MemWrite_in  = w;
        bus.MemRead_in   = r;
        bus.MemToReg_in  = m;
        bus.RegWrite_in  = rw;
        bus.AluResult_in = a;
        bus.WriteData_in = d;
        bus.Rd_in        = rd;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, ".rw"}, 32'(bus.RegWrite_out), 0);
        chk({tag, ".m2r"}, 32'(bus.MemToReg_out), 0);
        chk({tag, ".rdata"}, bus.ReadData_out, 0);
        chk({tag, ".alu"}, bus.AluResult_out, 0);
        chk({tag, ".rd"}, 32'(bus.Rd_out), 0);
        chk({tag, ".fault"}, 32'(bus.MisalignFault_out), 0);
        chk({tag, ".stall"}, 32'(bus.Stall_out), 0);
    endtask
    // One instruction: present it, count stall cycles, check the WB result.
    task automatic op(input string tag, input bit w, r, m, rw,
                      input logic [31:0] a, d, input logic [4:0] rd);
        bit  is_mem = w | r;
        bit  mis    = is_mem && (a % 4 != 0);
        int  idx    = int'((a / 4) % DW);
        int  stalls = 0;
        bit  chk_rd = 1'b1;
        logic [31:0] exp_rd = 32'h0;
        if (r && !w && !mis) begin
            exp_rd = ref_mem[idx];
            chk_rd = known[idx];
        end
        @(negedge clk);
        drive(w, r, m, rw, a, d, rd);
        forever begin
            #1;
            if (!bus.Stall_out) break;
            stalls++;
            if (stalls > 20) break;
            @(negedge clk);
        end
        chk({tag, ".stalls"}, stalls, (is_mem && !mis) ? LAT : 0);
        @(posedge clk);
        #1;
        chk({tag, ".rw"}, 32'(bus.RegWrite_out), mis ? 0 : 32'(rw));
        chk({tag, ".m2r"}, 32'(bus.MemToReg_out), mis ? 0 : 32'(m));
        chk({tag, ".fault"}, 32'(bus.MisalignFault_out), 32'(mis));
        if (chk_rd) chk({tag, ".rdata"}, bus.ReadData_out, exp_rd);
        if (!mis) begin
            chk({tag, ".alu"}, bus.AluResult_out, a);
            chk({tag, ".rd"}, 32'(bus.Rd_out), 32'(rd));
        end
        if (w && !mis) begin
            ref_mem[idx] = d;
            known[idx]   = 1'b1;
        end
    endtask
    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < DW; i++) known[i] = 1'b0;
        rst_n = 1'b0;
        drive(0, 0, 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        op("pass", 0, 0, 0, 1, 32'h1234, 32'h0, 5'd7);
        op("st10", 1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        op("ld10", 0, 1, 1, 1, 32'h10, 32'h0, 5'd3);
        op("mis_ld", 0, 1, 1, 1, 32'h13, 32'h0, 5'd4);
        op("mis_st", 1, 0, 0, 0, 32'h11, 32'h0BAD0BAD, 5'd0);
        op("ld10b", 0, 1, 1, 1, 32'h10, 32'h0, 5'd5);
        op("rw_both", 1, 1, 1, 1, 32'h14, 32'h55AA55AA, 5'd6);
        op("wrap_st", 1, 0, 0, 0, 32'h400, 32'hA5A5A5A5, 5'd0);
        op("wrap_ld", 0, 1, 1, 1, 32'h000, 32'h0, 5'd8);
        op("st20", 1, 0, 0, 0, 32'h20, 32'h0, 5'd0);
        // Abort a store to 0x20 during its first BUSY cycle
        @(negedge clk);
        drive(1, 0, 0, 0, 32'h20, 32'h1, 5'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        op("ld20", 0, 1, 1, 1, 32'h20, 32'h0, 5'd9);
        for (int i = 0; i < 200; i++) begin
            int   kind = int'($urandom_range(0, 3));
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
            op("rand", kind == 1 || ($urandom_range(0, 9) == 0), kind == 2,
               1'($urandom), 1'($urandom), a, $urandom, 5'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline, fed directly by the EX/MEM pipeline register and producing the MEM/WB register contents. Performs word-aligned loads and stores into an internal single-port data memory with a programmable access latency. Stalls the upstream pipeline while an access is in progress, flags misaligned accesses, and passes non-memory instructions through with one cycle of latency.

## Interface
- `DEPTH_WORDS`, 256: data memory size in 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: wait cycles per memory access; range 1..15.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `MemWrite_in`, `MemRead_in`, `MemToReg_in`, `RegWrite_in` in 1 each: control bits from EX/MEM.
- `AluResult_in` in 32: byte address for memory operations, or the result value for non-memory operations.
- `WriteData_in` in 32: store data.
- `Rd_in` in 5: destination register.
- `Stall_out` out 1: combinational; upstream must hold every `*_in` constant while this is high.
- `MemToReg_out`, `RegWrite_out` out 1 each: registered control to WB.
- `ReadData_out` out 32: registered load data.
- `AluResult_out` out 32: registered copy of `AluResult_in`.
- `Rd_out` out 5: registered destination register.
- `MisalignFault_out` out 1: registered; one-cycle pulse on a misaligned access.

## Operation
- Memory op (mem op) = `MemRead_in | MemWrite_in`. Word index = `AluResult_in[ADDR_W+1:2]`, where ADDR_W = log2(DEPTH_WORDS). Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS.
- Misaligned = mem op and `AluResult_in[1:0] != 0`.
  - No memory access and no stall.
  - Outputs load a bubble: `RegWrite_out=0`, `MemToReg_out=0`, `ReadData_out=0`.
  - `MisalignFault_out=1` for that one cycle.
- FSM, two states, IDLE and BUSY, with a 4-bit counter `cnt`.
  - **IDLE, non-memory instruction:** outputs take `*_in` directly, `ReadData_out=0`, `Stall_out=0`.
  - **IDLE, aligned mem op:** `Stall_out=1`, `cnt<=LATENCY-1`, go to BUSY. Outputs load a bubble.
  - **BUSY with `cnt!=0`:** `Stall_out=1`, `cnt` decrements. Outputs load a bubble.
  - **BUSY with `cnt==0`:**
    - `Stall_out=0`; the access happens at this edge.
    - A store writes the word. A load captures the memory word into `ReadData_out`.
    - Control, `AluResult_out` and `Rd_out` load from the inputs. Go to IDLE.
- `MemRead_in` and `MemWrite_in` both high: the write is performed, and `ReadData_out=0`.
- Memory contents are not reset. They are undefined until written.
- Reset values: all outputs 0, state IDLE, `cnt=0`.
- Reset mid-access aborts the access. A pending store is not committed.

## Timing
- Non-memory instruction: outputs are valid 1 cycle after it is presented.
- Aligned mem op:
  - occupies LATENCY+1 cycles;
  - `Stall_out` is high for exactly LATENCY cycles;
  - WB outputs are valid at the edge ending cycle LATENCY (counting the presentation cycle as 0).
- Back-to-back mem ops: the next op is accepted in the cycle after the previous op's final cycle. There is no idle gap beyond the stall.
- A load following a store to the same word returns the new data.
- `Stall_out` depends only on state, `cnt` and the current inputs. There is no path from outputs back to inputs.

## Structure
- Package `mem_stage_pkg`:
  - state enum `mem_state_t` {IDLE, BUSY};
  - `WORD_W=32`, `REG_ADDR_W=5`;
  - function `is_misaligned(addr)`.
- Sub-module `data_mem`: single-port synchronous RAM (DEPTH_WORDS×32) with `we`, `addr`, `wdata`, `rdata`. Read data is registered.
- The FSM, counter and MEM/WB output registers live in `mem_stage`.

## Test plan
All tests use the default parameters (DEPTH_WORDS=256, LATENCY=2).
- **Reset:** assert `rst_n=0` with random inputs → every output is 0 and `Stall_out=0` for non-memory inputs.
- **Pass-through:** `RegWrite_in=1`, `AluResult_in=0x1234`, `Rd_in=7` → one cycle later `RegWrite_out=1`, `AluResult_out=0x1234`, `Rd_out=7`, `ReadData_out=0`, with no stall.
- **Store then load:**
  - Store `0xDEADBEEF` to address 0x10 → `Stall_out` high for 2 cycles.
  - Then load from 0x10 → after 3 cycles `ReadData_out=0xDEADBEEF`, `MemToReg_out=1`.
- **Misaligned:** load from 0x13 → no stall; next cycle `MisalignFault_out=1`, `RegWrite_out=0`; memory is unchanged.
- **Wrap-around:** store `0xA5A5A5A5` to 0x400 (word 256) → a load from 0x000 returns `0xA5A5A5A5`.
- **Reset mid-access:** store `0x1` to 0x20 (previously 0), assert `rst_n` low during the first BUSY cycle → a later load from 0x20 returns 0.
